// File: rtl/telemetry_frame_scheduler_if.sv
// Bus bundle between the telemetry frame scheduler, its sources and the UART
// TX FIFO.
//   master : the scheduler (drives src_ack, fifo_wr, fifo_wdata)
//   slave  : sources plus FIFO (drive src_req, src_payload, fifo_full)
// Signals:
//   src_req      per-source request, held until the matching src_ack
//   src_payload  source i at [i*PAYLOAD_BYTES*8 +: PAYLOAD_BYTES*8], byte 0 = LSB
//   src_ack      one-hot, one-cycle pulse when a payload is captured
//   fifo_full    FIFO cannot take a byte this cycle
//   fifo_wr      write strobe to the FIFO
//   fifo_wdata   byte to write
interface telemetry_frame_scheduler_if #(
  parameter int NUM_SRC       = 4,
  parameter int PAYLOAD_BYTES = 4
);
  logic [NUM_SRC-1:0]                 src_req;
  logic [NUM_SRC*PAYLOAD_BYTES*8-1:0] src_payload;
  logic [NUM_SRC-1:0]                 src_ack;
  logic                               fifo_full;
  logic                               fifo_wr;
  logic [7:0]                         fifo_wdata;

  modport master (
    input  src_req, src_payload, fifo_full,
    output src_ack, fifo_wr, fifo_wdata
  );

  modport slave (
    output src_req, src_payload, fifo_full,
    input  src_ack, fifo_wr, fifo_wdata
  );
endinterface

// File: rtl/telemetry_frame_scheduler.sv
// Round-robin telemetry frame scheduler. Picks one requesting source, captures
// its payload and writes the frame SYNC, ID, payload (LSB first), CHECKSUM into
// the UART TX FIFO one byte per accepted write, honouring fifo_full.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   enable       new frames may start only while high (sampled in IDLE)
//   bus          source request/ack/payload and FIFO write bundle (master side)
//   busy         high whenever the FSM is not in IDLE
//   frame_count  completed frames, wraps at 16'hFFFF
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for enable and a request; grant here
// SYNC    | emitting SYNC_BYTE
// ID      | emitting winner index
// PAYLOAD | emitting latched payload byte[byte_idx]
// CSUM    | emitting checksum, then frame done
module telemetry_frame_scheduler #(
  parameter int          NUM_SRC       = 4,
  parameter int          PAYLOAD_BYTES = 4,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  telemetry_frame_scheduler_if.master  bus,
  output logic                         busy,
  output logic [15:0]                  frame_count
);

  localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int BIDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int PW     = PAYLOAD_BYTES * 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    ID      = 3'd2,
    PAYLOAD = 3'd3,
    CSUM    = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [IDX_W-1:0]    rr_ptr, winner, grant_idx;
  logic                grant_found, grant, accept, last_byte;
  logic [BIDX_W-1:0]   byte_idx;
  logic [PW-1:0]       payload_q;
  logic [7:0]          checksum, wdata, pay_byte, id_byte;
  logic [NUM_SRC-1:0]  ack_q;

  // First requester found scanning rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  always_comb begin : arb
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_SRC;
      if (!grant_found && bus.src_req[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

  assign grant     = (state == IDLE) && enable && grant_found;
  assign pay_byte  = payload_q[int'(byte_idx)*8 +: 8];
  assign id_byte   = 8'(winner);
  assign last_byte = (byte_idx == BIDX_W'(PAYLOAD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and FIFO write; a byte only advances on an accepted write.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    wdata   = 8'h00;
    case (state)
      IDLE: begin
        if (grant) state_n = SYNC;
      end
      SYNC: begin
        wdata  = SYNC_BYTE;
        accept = !bus.fifo_full;
        if (accept) state_n = ID;
      end
      ID: begin
        wdata  = id_byte;
        accept = !bus.fifo_full;
        if (accept) state_n = PAYLOAD;
      end
      PAYLOAD: begin
        wdata  = pay_byte;
        accept = !bus.fifo_full;
        if (accept && last_byte) state_n = CSUM;
      end
      CSUM: begin
        wdata  = checksum;
        accept = !bus.fifo_full;
        if (accept) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      winner      <= '0;
      payload_q   <= '0;
      checksum    <= 8'h00;
      byte_idx    <= '0;
      ack_q       <= '0;
      frame_count <= 16'h0000;
    end else begin
      ack_q <= '0;
      if (grant) begin
        winner            <= grant_idx;
        payload_q         <= bus.src_payload[int'(grant_idx)*PW +: PW];
        ack_q[grant_idx]  <= 1'b1;
        rr_ptr            <= (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + IDX_W'(1);
        checksum          <= 8'h00;
        byte_idx          <= '0;
      end
      if (accept) begin
        case (state)
          ID:      checksum <= checksum + id_byte;
          PAYLOAD: begin
            checksum <= checksum + pay_byte;
            byte_idx <= last_byte ? '0 : byte_idx + BIDX_W'(1);
          end
          CSUM:    frame_count <= frame_count + 16'd1;
          default: ;
        endcase
      end
    end
  end

  assign bus.src_ack    = ack_q;
  assign bus.fifo_wr    = accept;
  assign bus.fifo_wdata = wdata;
  assign busy           = (state != IDLE);

endmodule
